// File: rtl/rca_resp_checker_if.sv
// Bundles the golden-load, run-control, result-stream and status signals of rca_resp_checker.
// master drives stimulus and golden data; slave is the checker itself.
interface rca_resp_checker_if #(
    parameter int N  = 4,
    parameter int AW = 3
);
    logic          exp_wr_en;
    logic [AW-1:0] exp_wr_addr;
    logic [N:0]    exp_wr_data;
    logic          start;
    logic          res_valid;
    logic [N:0]    res_data;
    logic          res_ready;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_idx;
    logic [N:0]    first_err_got;
    logic [N:0]    first_err_exp;

    modport master (
        output exp_wr_en, exp_wr_addr, exp_wr_data, start, res_valid, res_data,
        input  res_ready, busy, done, pass, err_count,
        input  first_err_idx, first_err_got, first_err_exp
    );

    modport slave (
        input  exp_wr_en, exp_wr_addr, exp_wr_data, start, res_valid, res_data,
        output res_ready, busy, done, pass, err_count,
        output first_err_idx, first_err_got, first_err_exp
    );
endinterface

// File: rtl/rca_resp_checker.sv
// Checks RCA {Cout,Sum} results against a golden memory; RCA_CHK_STOP_ON_ERR_EN ends a run at the first mismatch.
// Latency: status updates 1 clk after each transfer; backpressure: res_ready is high only in RUN.
module rca_resp_checker #(
    parameter int N     = 4,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rca_resp_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ERR_MAX = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   err_q, err_d;
    logic [AW-1:0] fidx_q, fidx_d;
    logic [N:0]    fgot_q, fgot_d;
    logic [N:0]    fexp_q, fexp_d;
    logic [N:0]    mem_q [DEPTH];
    logic [N:0]    exp_word;
    logic          mism;

    // Golden memory is deliberately outside reset so a run can be repeated after a reset.
    always_ff @(posedge clk) begin
        if (bus.exp_wr_en && (state_q != RUN) && ({1'b0, bus.exp_wr_addr} < DEPTH_W)) begin
            mem_q[bus.exp_wr_addr] <= bus.exp_wr_data;
        end
    end

    assign exp_word = ({1'b0, idx_q} < DEPTH_W) ? mem_q[idx_q] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fgot_d  = fgot_q;
        fexp_d  = fexp_q;
        mism    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fgot_d  = '0;
                    fexp_d  = '0;
                end
            end
            RUN: begin
                if (bus.res_valid) begin
                    mism  = (bus.res_data != exp_word);
                    idx_d = idx_q + AW'(1);
                    if (mism) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + (AW+1)'(1);
                        end
                        if (err_q == '0) begin
                            fidx_d = idx_q;
                            fgot_d = bus.res_data;
                            fexp_d = exp_word;
                        end
                    end
                    if ({1'b0, idx_q} == LAST_W) begin
                        state_d = DONE;
                    end
`ifdef RCA_CHK_STOP_ON_ERR_EN
                    if (mism) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
            fexp_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
            fexp_q  <= fexp_d;
        end
    end

    // All status outputs decode straight from registers, so they are glitch-free.
    assign bus.res_ready     = (state_q == RUN);
    assign bus.busy          = (state_q == RUN);
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = (state_q == DONE) && (err_q == '0);
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = fidx_q;
    assign bus.first_err_got = fgot_q;
    assign bus.first_err_exp = fexp_q;
endmodule

// File: tb/tb_rca_resp_checker.sv
// Self-checking bench for rca_resp_checker: directed vector table, corner sequences, randomized runs vs a model.
module tb_rca_resp_checker;
    localparam int N     = 4;
    localparam int DEPTH = 5;
    localparam int AW    = 3;
`ifdef RCA_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct packed {
        logic [DEPTH-1:0][N:0] res;
        int                    maxgap;
        int                    e_err;
        int                    e_fidx;
        logic [N:0]            e_got;
        logic [N:0]            e_exp;
        int                    e_nx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rca_resp_checker_if #(.N(N), .AW(AW)) bus ();
    rca_resp_checker #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         run_err;
    int         nx_cnt;
    logic [N:0] gold [DEPTH];
    logic [N:0] stim [DEPTH];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, expv, $time);
        end
    endtask

    task automatic load_gold();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.exp_wr_en   = 1'b1;
            bus.exp_wr_addr = AW'(i);
            bus.exp_wr_data = gold[i];
        end
        @(negedge clk);
        bus.exp_wr_en = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        run_err = 0;
        nx_cnt  = 0;
        check("busy_in_run", 32'(bus.busy), 32'd1);
        check("ready_in_run", 32'(bus.res_ready), 32'd1);
        check("done_cleared", 32'(bus.done), 32'd0);
        check("err_cleared", 32'(bus.err_count), 32'd0);
    endtask

    // Presents stim[first..first+n-1] with random idle gaps; stops offering once ready is gone.
    task automatic send_words(input int first, input int n, input int maxgap);
        for (int i = first; i < first + n; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                bus.res_valid = 1'b0;
                bus.res_data  = (N+1)'($urandom);
                @(negedge clk);
            end
            bus.res_valid = 1'b1;
            bus.res_data  = stim[i];
            if (!bus.res_ready) break;
            @(negedge clk);
            nx_cnt++;
            if (stim[i] !== gold[i]) run_err++;
            check("err_step", 32'(bus.err_count), 32'(run_err));
            check("done_step", 32'(bus.done), 32'((i == DEPTH - 1) || (STOP && run_err > 0)));
        end
        bus.res_valid = 1'b0;
    endtask

    task automatic finish_check(input string nm, input int e_err, input int e_fidx,
                                input logic [N:0] e_got, input logic [N:0] e_exp, input int e_nx);
        check({nm, "_xfers"}, 32'(nx_cnt), 32'(e_nx));
        check({nm, "_done"}, 32'(bus.done), 32'd1);
        check({nm, "_busy"}, 32'(bus.busy), 32'd0);
        check({nm, "_pass"}, 32'(bus.pass), 32'(e_err == 0));
        check({nm, "_err"}, 32'(bus.err_count), 32'(e_err));
        check({nm, "_fidx"}, 32'(bus.first_err_idx), 32'(e_fidx));
        check({nm, "_fgot"}, 32'(bus.first_err_got), 32'(e_got));
        check({nm, "_fexp"}, 32'(bus.first_err_exp), 32'(e_exp));
        // Offer an extra bad word in DONE: it must be refused and change nothing.
        bus.res_valid = 1'b1;
        bus.res_data  = ~gold[0];
        check({nm, "_ready_done0"}, 32'(bus.res_ready), 32'd0);
        @(negedge clk);
        check({nm, "_ready_done1"}, 32'(bus.res_ready), 32'd0);
        check({nm, "_err_hold"}, 32'(bus.err_count), 32'(e_err));
        check({nm, "_done_hold"}, 32'(bus.done), 32'd1);
        bus.res_valid = 1'b0;
    endtask

    function automatic void model(output int e_err, output int e_fidx, output logic [N:0] e_got,
                                  output logic [N:0] e_exp, output int e_nx);
        e_err  = 0;
        e_fidx = 0;
        e_got  = '0;
        e_exp  = '0;
        e_nx   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e_nx++;
            if (stim[i] != gold[i]) begin
                if (e_err == 0) begin
                    e_fidx = i;
                    e_got  = stim[i];
                    e_exp  = gold[i];
                end
                e_err++;
                if (STOP) break;
            end
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tv [6];
        int         m_err, m_fidx, m_nx;
        logic [N:0] m_got, m_exp;

        rst_n           = 1'b0;
        bus.exp_wr_en   = 1'b0;
        bus.exp_wr_addr = '0;
        bus.exp_wr_data = '0;
        bus.start       = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_data    = '0;

        gold[0] = 5'b01000;
        gold[1] = 5'b10000;
        gold[2] = 5'b10011;
        gold[3] = 5'b10000;
        gold[4] = 5'b00001;

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) tv[r].res[i] = gold[i];
            tv[r].maxgap = 0;
            tv[r].e_err  = 0;
            tv[r].e_fidx = 0;
            tv[r].e_got  = '0;
            tv[r].e_exp  = '0;
            tv[r].e_nx   = DEPTH;
        end
        // 1: Cout dropped on word 2, word 4 zeroed
        tv[1].res[2] = 5'b00011;
        tv[1].res[4] = 5'b00000;
        tv[1].e_err  = STOP ? 1 : 2;
        tv[1].e_fidx = 2;
        tv[1].e_got  = 5'b00011;
        tv[1].e_exp  = 5'b10011;
        tv[1].e_nx   = STOP ? 3 : 5;
        // 2: correct stream with idle gaps
        tv[2].maxgap = 3;
        // 3: single mismatch at index 1
        tv[3].res[1] = 5'b00000;
        tv[3].maxgap = 1;
        tv[3].e_err  = 1;
        tv[3].e_fidx = 1;
        tv[3].e_got  = 5'b00000;
        tv[3].e_exp  = 5'b10000;
        tv[3].e_nx   = STOP ? 2 : 5;
        // 4: every word inverted
        for (int i = 0; i < DEPTH; i++) tv[4].res[i] = ~gold[i];
        tv[4].e_err  = STOP ? 1 : 5;
        tv[4].e_got  = 5'b10111;
        tv[4].e_exp  = 5'b01000;
        tv[4].e_nx   = STOP ? 1 : 5;
        // 5: only the last word wrong
        tv[5].res[4] = 5'b00000;
        tv[5].maxgap = 2;
        tv[5].e_err  = 1;
        tv[5].e_fidx = 4;
        tv[5].e_exp  = 5'b00001;

        #12;
        check("rst_ready", 32'(bus.res_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_err", 32'(bus.err_count), 32'd0);
        check("rst_fidx", 32'(bus.first_err_idx), 32'd0);
        check("rst_fgot", 32'(bus.first_err_got), 32'd0);
        check("rst_fexp", 32'(bus.first_err_exp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load_gold();
        // Out-of-range writes must not disturb the golden words.
        @(negedge clk);
        bus.exp_wr_en   = 1'b1;
        bus.exp_wr_addr = 3'd5;
        bus.exp_wr_data = 5'b11111;
        @(negedge clk);
        bus.exp_wr_addr = 3'd7;
        @(negedge clk);
        bus.exp_wr_en = 1'b0;

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) stim[i] = tv[r].res[i];
            do_start();
            send_words(0, DEPTH, tv[r].maxgap);
            finish_check($sformatf("vec%0d", r), tv[r].e_err, tv[r].e_fidx,
                         tv[r].e_got, tv[r].e_exp, tv[r].e_nx);
        end

        // Golden write and start while busy are both ignored.
        for (int i = 0; i < DEPTH; i++) stim[i] = gold[i];
        do_start();
        send_words(0, 2, 0);
        bus.exp_wr_en   = 1'b1;
        bus.exp_wr_addr = '0;
        bus.exp_wr_data = 5'b11111;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.exp_wr_en = 1'b0;
        bus.start     = 1'b0;
        send_words(2, DEPTH - 2, 0);
        finish_check("wr_in_run", 0, 0, '0, '0, DEPTH);
        do_start();
        send_words(0, DEPTH, 1);
        finish_check("rerun", 0, 0, '0, '0, DEPTH);

        // Asynchronous reset after two transfers, one of them bad.
        stim[1] = 5'b00000;
        do_start();
        send_words(0, 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_ready", 32'(bus.res_ready), 32'd0);
        check("mid_rst_err", 32'(bus.err_count), 32'd0);
        check("mid_rst_fexp", 32'(bus.first_err_exp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) stim[i] = gold[i];
        do_start();
        send_words(0, DEPTH, 2);
        finish_check("after_rst", 0, 0, '0, '0, DEPTH);

        // Randomized golden sets and result streams against the model.
        for (int r = 0; r < 40; r++) begin
            if (r % 4 == 0) begin
                for (int i = 0; i < DEPTH; i++) gold[i] = (N+1)'($urandom);
                load_gold();
            end
            for (int i = 0; i < DEPTH; i++) begin
                stim[i] = ($urandom_range(2, 0) == 0) ? (N+1)'($urandom) : gold[i];
            end
            model(m_err, m_fidx, m_got, m_exp, m_nx);
            do_start();
            send_words(0, DEPTH, 3);
            finish_check($sformatf("rand%0d", r), m_err, m_fidx, m_got, m_exp, m_nx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
